// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the instruction/data memory request arbiter.
//   arb_state_t       - arbiter FSM states (IDLE, ISSUE, WAIT, DELIVER)
//   GRANT_INST/DATA   - encoding of the granted requester
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: all handshake/bus signals around the arbiter.
//   inst_*  - fetch requester request/response channels
//   data_*  - load/store requester request/response channels
//   mem_*   - shared memory request/response channels
// Modports: slave = arbiter view, master = surrounding core + memory view.
interface mem_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              inst_req_valid;
  logic              inst_req_ready;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_rsp_valid;
  logic              inst_rsp_ready;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req_valid;
  logic              data_req_ready;
  logic [ADDR_W-1:0] data_addr;
  logic              data_we;
  logic [DATA_W-1:0] data_wdata;
  logic [STRB_W-1:0] data_strb;
  logic              data_rsp_valid;
  logic              data_rsp_ready;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_strb;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req_valid, inst_addr, inst_rsp_ready,
    input  data_req_valid, data_addr, data_we, data_wdata, data_strb, data_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output inst_req_ready, inst_rsp_valid, inst_rdata,
    output data_req_ready, data_rsp_valid, data_rdata,
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_strb, mem_rsp_ready
  );

  modport master (
    output inst_req_valid, inst_addr, inst_rsp_ready,
    output data_req_valid, data_addr, data_we, data_wdata, data_strb, data_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  inst_req_ready, inst_rsp_valid, inst_rdata,
    input  data_req_ready, data_rsp_valid, data_rdata,
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_strb, mem_rsp_ready
  );

endinterface

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational grant selection between fetch and data requests.
//   inst_valid, data_valid - pending requests
//   last_grant             - requester granted most recently (round-robin only)
//   grant                  - selected requester (GRANT_INST / GRANT_DATA)
//   any_valid              - at least one request pending
// MEM_ARB_RR_EN defined: round-robin on contention; otherwise data beats inst.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic inst_valid,
  input  logic data_valid,
  input  logic last_grant,
  output logic grant,
  output logic any_valid
);

  assign any_valid = inst_valid | data_valid;

`ifdef MEM_ARB_RR_EN
  // On contention the requester not granted last time wins.
  always_comb begin
    grant = GRANT_INST;
    if (inst_valid && data_valid) begin
      grant = (last_grant == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
    end else if (data_valid) begin
      grant = GRANT_DATA;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = GRANT_INST;
    if (data_valid) begin
      grant = GRANT_DATA;
    end
  end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory port between instruction fetch and data
// access. One transaction outstanding at a time: accept -> issue -> (loads)
// wait for read data -> deliver to the granted requester.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - mem_req_arbiter_if.slave carrying the inst, data and mem channels
// MEM_ARB_RR_EN defined: round-robin arbitration with a last-grant register.
module mem_req_arbiter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.slave bus
);

  arb_state_t state;
  logic       grant;
  logic       sel;
  logic       any_valid;
  logic       last_grant;
  logic       accept;

  mem_arb_select u_select (
    .inst_valid (bus.inst_req_valid),
    .data_valid (bus.data_req_valid),
    .last_grant (last_grant),
    .grant      (sel),
    .any_valid  (any_valid)
  );

  // Request ready is combinational from the registered state; held low in reset.
  assign bus.inst_req_ready = ~rst & (state == IDLE) & bus.inst_req_valid & (sel == GRANT_INST);
  assign bus.data_req_ready = ~rst & (state == IDLE) & bus.data_req_valid & (sel == GRANT_DATA);
  assign accept             = (state == IDLE) & any_valid;

`ifdef MEM_ARB_RR_EN
  // Last-grant register, updated on every requester handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_INST;
    end else if (accept) begin
      last_grant <= sel;
    end
  end
`else
  assign last_grant = GRANT_INST;
`endif

  // Arbiter FSM with registered handshake outputs and latched request/response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      grant              <= GRANT_INST;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_rsp_ready  <= 1'b0;
      bus.inst_rsp_valid <= 1'b0;
      bus.data_rsp_valid <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_wdata      <= '0;
      bus.mem_strb       <= '0;
      bus.inst_rdata     <= '0;
      bus.data_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant             <= sel;
            bus.mem_req_valid <= 1'b1;
            state             <= ISSUE;
            if (sel == GRANT_DATA) begin
              bus.mem_addr  <= bus.data_addr;
              bus.mem_we    <= bus.data_we;
              bus.mem_wdata <= bus.data_wdata;
              bus.mem_strb  <= bus.data_strb;
            end else begin
              // Fetches are always reads.
              bus.mem_addr  <= bus.inst_addr;
              bus.mem_we    <= 1'b0;
              bus.mem_wdata <= '0;
              bus.mem_strb  <= '0;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            if (bus.mem_we) begin
              // Stores complete on the request handshake; no response.
              state <= IDLE;
            end else begin
              bus.mem_rsp_ready <= 1'b1;
              state             <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            bus.mem_rsp_ready <= 1'b0;
            state             <= DELIVER;
            if (grant == GRANT_DATA) begin
              bus.data_rdata     <= bus.mem_rdata;
              bus.data_rsp_valid <= 1'b1;
            end else begin
              bus.inst_rdata     <= bus.mem_rdata;
              bus.inst_rsp_valid <= 1'b1;
            end
          end
        end
        DELIVER: begin
          if ((grant == GRANT_DATA) ? bus.data_rsp_ready : bus.inst_rsp_ready) begin
            bus.inst_rsp_valid <= 1'b0;
            bus.data_rsp_valid <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
